// File: rtl/serdes_rx_align_if.sv
// serdes_rx_align_if: raw SERDES receive word in, realigned word and lock status out
interface serdes_rx_align_if;
  logic [15:0] ser_r;
  logic        ser_rkmsb;
  logic        ser_rklsb;
  logic [15:0] out_data;
  logic        out_kmsb;
  logic        out_klsb;
  logic        out_valid;
  logic        locked;
  logic        odd;
  logic        realign;
  modport master (
    output ser_r, ser_rkmsb, ser_rklsb,
    input  out_data, out_kmsb, out_klsb, out_valid, locked, odd, realign
  );
  modport slave (
    input  ser_r, ser_rkmsb, ser_rklsb,
    output out_data, out_kmsb, out_klsb, out_valid, locked, odd, realign
  );
endinterface

// File: rtl/serdes_rx_align.sv
// serdes_rx_align: hunts K28.5 commas, locks to their lane and repacks byte-swapped words
module serdes_rx_align #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 3
) (
  input logic clk,
  input logic rst,
  serdes_rx_align_if.slave bus
);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_r0_data, r_r1_data;
  logic        r_r0_kmsb, r_r0_klsb, r_r1_kmsb;
  logic [15:0] r_out_data;
  logic        r_out_kmsb, r_out_klsb, r_out_valid, r_locked, r_odd, r_realign;
  logic        w_c_even, w_c_odd, w_hit, w_miss;
  logic [3:0]  w_cnt_inc;
  // a word carrying commas in both lanes is never a valid hit
  always_comb begin
    w_c_even  = r_r0_klsb && r_r0_data[7:0] == COMMA;
    w_c_odd   = r_r0_kmsb && r_r0_data[15:8] == COMMA;
    w_hit     = (r_odd ? w_c_odd : w_c_even) && !(w_c_even && w_c_odd);
    w_miss    = (w_c_even || w_c_odd) && !w_hit;
    w_cnt_inc = r_cnt + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r0_data  <= '0;
      r_r0_kmsb  <= 1'b0;
      r_r0_klsb  <= 1'b0;
      r_r1_data  <= '0;
      r_r1_kmsb  <= 1'b0;
      r_out_data <= '0;
      r_out_kmsb <= 1'b0;
      r_out_klsb <= 1'b0;
    end else begin
      r_r0_data  <= bus.ser_r;
      r_r0_kmsb  <= bus.ser_rkmsb;
      r_r0_klsb  <= bus.ser_rklsb;
      r_r1_data  <= r_r0_data;
      r_r1_kmsb  <= r_r0_kmsb;
      r_out_data <= r_odd ? {r_r0_data[7:0], r_r1_data[15:8]} : r_r0_data;
      r_out_kmsb <= r_odd ? r_r0_klsb : r_r0_kmsb;
      r_out_klsb <= r_odd ? r_r1_kmsb : r_r0_klsb;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_odd       <= 1'b0;
      r_realign   <= 1'b0;
      r_locked    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_realign <= 1'b0;
      case (r_state)
        HUNT: if (w_c_even ^ w_c_odd) begin
          r_odd     <= w_c_odd;
          r_realign <= w_c_odd != r_odd;
          if (LOCK_N == 4'd1) begin
            r_state     <= LOCKED;
            r_cnt       <= '0;
            r_locked    <= 1'b1;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= CHECK;
            r_cnt   <= 4'd1;
          end
        end
        CHECK: if (w_hit) begin
          if (w_cnt_inc == LOCK_N) begin
            r_state     <= LOCKED;
            r_cnt       <= '0;
            r_locked    <= 1'b1;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end else if (w_miss) begin
          r_state <= HUNT;
          r_cnt   <= '0;
        end
        LOCKED: if (w_hit) begin
          r_cnt <= '0;
        end else if (w_miss) begin
          if (w_cnt_inc == LOSS_N) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_locked    <= 1'b0;
            r_out_valid <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= HUNT;
          r_cnt   <= '0;
        end
      endcase
    end
  end
  assign bus.out_data  = r_out_data;
  assign bus.out_kmsb  = r_out_kmsb;
  assign bus.out_klsb  = r_out_klsb;
  assign bus.out_valid = r_out_valid;
  assign bus.locked    = r_locked;
  assign bus.odd       = r_odd;
  assign bus.realign   = r_realign;
endmodule
